// File: rtl/sram_block_reader.sv
// sram_block_reader
//   Read-side streamer for the 32768x64 result SRAM filled by the 2D-DCT
//   datapath. A start request latches a base address and a word count; the
//   block then issues sequential SRAM reads (wrapping at the top of the
//   address space) and presents the returned words on a valid/ready stream.
//   A small FIFO absorbs the SRAM's 1-cycle read latency and downstream
//   backpressure.
//
// Ports
//   clk         system clock, rising edge
//   reset       asynchronous, active-high reset
//   start       single-cycle request, honoured only while idle
//   base_addr   first word address (latched on accepted start)
//   word_count  number of words to read, 0..2^ADDR_W (latched on accepted start)
//   busy        transfer in progress
//   done        one-cycle completion pulse
//   sram_rd_en  SRAM read strobe
//   sram_addr   SRAM read address (holds while sram_rd_en is low)
//   sram_rdata  SRAM read data, valid the cycle after sram_rd_en
//   out_valid   stream word valid
//   out_ready   downstream accept
//   out_data    stream word (FIFO head, zero while empty)
//   out_last    final word of the run
module sram_block_reader #(
  parameter int ADDR_W     = 15,
  parameter int DATA_W     = 64,
  parameter int FIFO_DEPTH = 4
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              start,
  input  logic [ADDR_W-1:0] base_addr,
  input  logic [ADDR_W:0]   word_count,
  output logic              busy,
  output logic              done,
  output logic              sram_rd_en,
  output logic [ADDR_W-1:0] sram_addr,
  input  logic [DATA_W-1:0] sram_rdata,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [DATA_W-1:0] out_data,
  output logic              out_last
);

  localparam int PW = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
  localparam int CW = $clog2(FIFO_DEPTH + 1);

  typedef enum logic [1:0] {IDLE, RUN, FLUSH} state_t;

  state_t            state_q;
  logic [ADDR_W-1:0] base_q;
  logic [ADDR_W:0]   count_q;
  logic [ADDR_W:0]   issued_q;
  logic [ADDR_W:0]   popped_q;
  logic [ADDR_W:0]   popped_d;
  logic              busy_q;
  logic              done_q;
  logic              rd_en_q;
  logic [ADDR_W-1:0] addr_q;
  // Set for the cycle in which the SRAM returns data for last cycle's read.
  logic              pend_q;

  logic [DATA_W-1:0] fifo_mem [FIFO_DEPTH];
  logic [PW-1:0]     wr_ptr_q;
  logic [PW-1:0]     rd_ptr_q;
  logic [CW-1:0]     fcnt_q;
  logic [CW-1:0]     fcnt_d;
  logic [CW:0]       commit_nxt;

  logic push;
  logic pop;
  logic remaining_nz;
  logic room;
  logic issue;

  assign push         = pend_q;
  assign pop          = out_valid & out_ready;
  assign fcnt_d       = fcnt_q + CW'(push) - CW'(pop);
  assign popped_d     = popped_q + (ADDR_W+1)'(pop);
  assign remaining_nz = (issued_q != count_q);

  // Words committed for the next cycle: FIFO contents after this cycle's
  // push/pop, plus the read currently on the bus (it lands one cycle later),
  // plus the read we are about to issue. Keeping this within FIFO_DEPTH
  // guarantees every issued read has a FIFO slot when its data returns.
  assign commit_nxt = {1'b0, fcnt_d} + (CW+1)'(rd_en_q) + (CW+1)'(1);
  assign room       = (commit_nxt <= (CW+1)'(FIFO_DEPTH));
  assign issue      = (state_q == RUN) && remaining_nz && room;

  assign busy       = busy_q;
  assign done       = done_q;
  assign sram_rd_en = rd_en_q;
  assign sram_addr  = addr_q;
  assign out_valid  = (fcnt_q != '0);
  assign out_data   = out_valid ? fifo_mem[rd_ptr_q] : '0;
  assign out_last   = out_valid && ((popped_q + (ADDR_W+1)'(1)) == count_q);

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q  <= IDLE;
      base_q   <= '0;
      count_q  <= '0;
      issued_q <= '0;
      popped_q <= '0;
      busy_q   <= 1'b0;
      done_q   <= 1'b0;
      rd_en_q  <= 1'b0;
      addr_q   <= '0;
      pend_q   <= 1'b0;
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      fcnt_q   <= '0;
    end else begin
      done_q   <= 1'b0;
      rd_en_q  <= 1'b0;
      pend_q   <= rd_en_q;
      fcnt_q   <= fcnt_d;
      popped_q <= popped_d;

      if (push) begin
        wr_ptr_q <= (wr_ptr_q == PW'(FIFO_DEPTH - 1)) ? '0 : wr_ptr_q + PW'(1);
      end
      if (pop) begin
        rd_ptr_q <= (rd_ptr_q == PW'(FIFO_DEPTH - 1)) ? '0 : rd_ptr_q + PW'(1);
      end

      case (state_q)
        IDLE: begin
          if (start) begin
            base_q   <= base_addr;
            count_q  <= word_count;
            popped_q <= '0;
            busy_q   <= 1'b1;
            if (word_count == '0) begin
              issued_q <= '0;
              state_q  <= FLUSH;
            end else begin
              // First read goes out in the cycle right after the start.
              rd_en_q  <= 1'b1;
              addr_q   <= base_addr;
              issued_q <= (ADDR_W+1)'(1);
              state_q  <= RUN;
            end
          end
        end

        RUN: begin
          if (issue) begin
            rd_en_q  <= 1'b1;
            addr_q   <= base_q + issued_q[ADDR_W-1:0];
            issued_q <= issued_q + (ADDR_W+1)'(1);
          end else if (!remaining_nz) begin
            state_q <= FLUSH;
          end
        end

        FLUSH: begin
          if (popped_d == count_q) begin
            busy_q  <= 1'b0;
            done_q  <= 1'b1;
            state_q <= IDLE;
          end
        end

        default: state_q <= IDLE;
      endcase
    end
  end

  // FIFO storage carries data only; occupancy is tracked by the control regs.
  always_ff @(posedge clk) begin
    if (push) begin
      fifo_mem[wr_ptr_q] <= sram_rdata;
    end
  end

  a_no_fifo_overflow: assert property (@(posedge clk) disable iff (reset)
    !(push && !pop && (fcnt_q == CW'(FIFO_DEPTH))));

endmodule

// File: tb/tb_sram_block_reader.sv
module tb_sram_block_reader;

  localparam int AW    = 15;
  localparam int DW    = 64;
  localparam int DEPTH = 4;
  localparam int MEMSZ = 32768;

  logic          clk = 1'b0;
  logic          reset;
  logic          start;
  logic [AW-1:0] base_addr;
  logic [AW:0]   word_count;
  logic          busy;
  logic          done;
  logic          sram_rd_en;
  logic [AW-1:0] sram_addr;
  logic [DW-1:0] sram_rdata;
  logic          out_valid;
  logic          out_ready;
  logic [DW-1:0] out_data;
  logic          out_last;

  sram_block_reader #(.ADDR_W(AW), .DATA_W(DW), .FIFO_DEPTH(DEPTH)) dut (
    .clk(clk), .reset(reset), .start(start), .base_addr(base_addr),
    .word_count(word_count), .busy(busy), .done(done),
    .sram_rd_en(sram_rd_en), .sram_addr(sram_addr), .sram_rdata(sram_rdata),
    .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data),
    .out_last(out_last)
  );

  always #5 clk = ~clk;

  // Synchronous single-port SRAM contents.
  logic [DW-1:0] mem [MEMSZ];
  always @(posedge clk) if (sram_rd_en) sram_rdata <= mem[sram_addr];

  int checks = 0;
  int errors = 0;
  int cyc = 0;

  // Reference model state: the words and addresses a run must produce.
  logic [DW-1:0] exp_data [$];
  bit            exp_last [$];
  int            exp_addr [$];
  int exp_done_cyc  = -1;
  int exp_first_rd  = -1;
  int exp_first_vld = -1;
  int issued_n = 0;
  int popped_n = 0;
  int hs_total = 0;
  int done_cnt = 0;
  int last_done_cyc = 0;
  int rmode = 0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s: actual=0x%0h required=0x%0h (cycle %0d)", name, act, req, cyc);
    end
  endtask

  task automatic fail_event(input string name);
    checks++;
    errors++;
    $display("FAIL %s: actual=event required=none (cycle %0d)", name, cyc);
  endtask

  initial forever begin
    @(posedge clk);
    cyc++;
  end

  // Downstream ready patterns: always, 1-0-0 repeating, random.
  initial begin
    int phase = 0;
    out_ready = 1'b1;
    forever begin
      @(posedge clk);
      #1;
      case (rmode)
        1:       begin out_ready = (phase == 0); phase = (phase + 1) % 3; end
        2:       out_ready = 1'($urandom_range(0, 1));
        default: out_ready = 1'b1;
      endcase
    end
  end

  // Monitor / scoreboard.
  initial begin
    bit            prev_stall = 0;
    logic [DW-1:0] prev_data  = '0;
    bit            prev_last  = 0;
    forever begin
      @(negedge clk);
      if (reset) begin
        prev_stall = 0;
        continue;
      end
      if (exp_done_cyc == cyc) begin
        chk("done_pulse", done, 1);
        chk("busy_low_at_done", busy, 0);
        exp_done_cyc = -1;
      end else if (done) begin
        fail_event("done_unexpected");
      end
      if (done) begin
        done_cnt++;
        last_done_cyc = cyc;
      end
      if (sram_rd_en) begin
        if (exp_first_rd != -1) begin
          chk("first_rd_cycle", cyc, exp_first_rd);
          exp_first_rd = -1;
        end
        if (exp_addr.size() == 0) fail_event("rd_en_unexpected");
        else chk("rd_addr", sram_addr, exp_addr.pop_front());
        issued_n++;
      end
      chk("occupancy_le_depth", (issued_n - popped_n) <= DEPTH, 1);
      if (prev_stall) begin
        chk("valid_held", out_valid, 1);
        chk("data_held", out_data, prev_data);
        chk("last_held", out_last, prev_last);
      end
      if (out_valid) begin
        if (exp_first_vld != -1) begin
          chk("first_valid_cycle", cyc, exp_first_vld);
          exp_first_vld = -1;
        end
        if (out_ready) begin
          popped_n++;
          hs_total++;
          if (exp_data.size() == 0) fail_event("word_unexpected");
          else begin
            logic [DW-1:0] d;
            bit            l;
            d = exp_data.pop_front();
            l = exp_last.pop_front();
            chk("out_data", out_data, d);
            chk("out_last", out_last, l);
            if (l) exp_done_cyc = cyc + 1;
          end
        end
      end
      prev_stall = out_valid && !out_ready;
      prev_data  = out_data;
      prev_last  = out_last;
    end
  end

  // Called just after a rising edge; raises start for this cycle.
  task automatic issue_start(input int base, input int wc);
    for (int i = 0; i < wc; i++) begin
      int a;
      a = (base + i) % MEMSZ;
      exp_addr.push_back(a);
      exp_data.push_back(mem[a]);
      exp_last.push_back(i == wc - 1);
    end
    base_addr  = AW'(base);
    word_count = (AW+1)'(wc);
    start      = 1'b1;
    if (wc == 0) exp_done_cyc = cyc + 2;
    else begin
      exp_first_rd  = cyc + 1;
      exp_first_vld = cyc + 3;
    end
  endtask

  task automatic wait_done(input int wc);
    int snap;
    int budget;
    snap   = done_cnt;
    budget = wc * 6 + 64;
    for (int i = 0; i < budget && done_cnt == snap; i++) begin
      @(negedge clk);
      #1;
    end
    if (done_cnt == snap) begin
      checks++;
      errors++;
      $display("FAIL done_timeout: actual=no_done required=done (cycle %0d)", cyc);
    end
  endtask

  task automatic run(input int base, input int wc, input int lat);
    int s;
    @(posedge clk);
    #1;
    issue_start(base, wc);
    s = cyc;
    @(posedge clk);
    #1;
    start = 1'b0;
    if (wc > 0) begin
      @(negedge clk);
      chk("busy_running", busy, 1);
    end
    wait_done(wc);
    if (lat >= 0) chk("done_latency", last_done_cyc - s, lat);
  endtask

  initial begin
    int s;
    reset      = 1'b1;
    start      = 1'b0;
    base_addr  = '0;
    word_count = '0;
    for (int i = 0; i < MEMSZ; i++) mem[i] = {$urandom, $urandom};

    repeat (2) @(posedge clk);
    @(negedge clk);
    chk("rst_busy", busy, 0);
    chk("rst_done", done, 0);
    chk("rst_rd_en", sram_rd_en, 0);
    chk("rst_addr", sram_addr, 0);
    chk("rst_valid", out_valid, 0);
    chk("rst_last", out_last, 0);
    chk("rst_data", out_data, 0);
    @(posedge clk);
    #1;
    reset = 1'b0;
    repeat (2) @(posedge clk);

    // Basic run with full throughput, then the same run under backpressure.
    rmode = 0;
    run(16'h0010, 8, 11);
    rmode = 1;
    run(16'h0010, 8, -1);
    rmode = 0;

    // Address wrap and single-word run.
    run(16'h7FFE, 4, 7);
    run(16'h1234, 1, 4);

    // Empty run, with a second start on the done cycle.
    @(posedge clk);
    #1;
    issue_start(16'h0100, 0);
    s = cyc;
    @(posedge clk);
    #1;
    start = 1'b0;
    @(posedge clk);
    #1;
    issue_start(16'h0200, 3);
    @(posedge clk);
    #1;
    start = 1'b0;
    chk("zero_run_done_cycle", last_done_cyc - s, 2);
    wait_done(3);
    chk("b2b_done_latency", last_done_cyc - (s + 2), 6);

    // Reset in the middle of a 16-word run.
    @(posedge clk);
    #1;
    issue_start(16'h0300, 16);
    @(posedge clk);
    #1;
    start = 1'b0;
    s = hs_total;
    for (int i = 0; i < 200 && hs_total < s + 3; i++) begin
      @(negedge clk);
      #1;
    end
    chk("hs_before_reset", hs_total - s, 3);
    reset = 1'b1;
    #1;
    chk("mid_rst_busy", busy, 0);
    chk("mid_rst_done", done, 0);
    chk("mid_rst_rd_en", sram_rd_en, 0);
    chk("mid_rst_addr", sram_addr, 0);
    chk("mid_rst_valid", out_valid, 0);
    chk("mid_rst_last", out_last, 0);
    chk("mid_rst_data", out_data, 0);
    exp_data.delete();
    exp_last.delete();
    exp_addr.delete();
    exp_done_cyc  = -1;
    exp_first_rd  = -1;
    exp_first_vld = -1;
    issued_n = 0;
    popped_n = 0;
    repeat (2) @(posedge clk);
    #1;
    reset = 1'b0;
    repeat (6) @(posedge clk);
    run(16'h0040, 2, 5);

    // Randomized runs under random backpressure.
    rmode = 2;
    for (int r = 0; r < 6; r++) run(int'($urandom_range(0, MEMSZ - 1)), int'($urandom_range(1, 40)), -1);
    rmode = 0;

    // Whole memory in one run.
    run(0, MEMSZ, MEMSZ + 3);

    repeat (4) @(posedge clk);
    chk("exp_data_drained", exp_data.size(), 0);
    chk("exp_addr_drained", exp_addr.size(), 0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
